// File: rtl/genius_controller_pkg.sv
// Shared types for the Genius game controller: state encoding and the control-output bundle.
// The state values are fixed so that the datapath and benches can decode them directly.
package genius_controller_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StInit   = 3'd0,
    StSetup  = 3'd1,
    StSeq    = 3'd2,
    StWait   = 3'd3,
    StPlay   = 3'd4,
    StCheck  = 3'd5,
    StNext   = 3'd6,
    StResult = 3'd7
  } state_e;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } ctrl_t;

  // Moore decode: every control not named for a state stays low.
  function automatic ctrl_t decode_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StInit:   begin c.r1 = 1'b1; c.r2 = 1'b1; end
      StSetup:  c.e1 = 1'b1;
      StSeq:    c.e3 = 1'b1;
      StPlay:   c.e2 = 1'b1;
      StNext:   begin c.r2 = 1'b1; c.e4 = 1'b1; end
      StResult: c.sel = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/genius_controller_if.sv
// Controller <-> datapath bundle: ENTER button and status flags in, counter/enable/select out.
// master = controller side, slave = datapath side.
interface genius_controller_if;
  logic KEY0_N;
  logic end_FPGA;
  logic end_User;
  logic end_time;
  logic win;
  logic match;
  logic R1;
  logic R2;
  logic E1;
  logic E2;
  logic E3;
  logic E4;
  logic SEL;

  modport master (
    input  KEY0_N, end_FPGA, end_User, end_time, win, match,
    output R1, R2, E1, E2, E3, E4, SEL
  );

  modport slave (
    output KEY0_N, end_FPGA, end_User, end_time, win, match,
    input  R1, R2, E1, E2, E3, E4, SEL
  );
endinterface

// File: rtl/key_edge_sync.sv
// Synchronizes an active-low asynchronous button and emits a one-cycle registered pulse
// on each press; a held button yields a single pulse.
module key_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  // Chain carries the inverted level so a cleared chain means "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ~key_n};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/genius_controller.sv
// Control FSM for the Genius (Simon) datapath. Build with GENIUS_TIMEOUT_EN defined to let
// end_time in PLAY end the game as a loss; otherwise end_time is ignored.
module genius_controller
  import genius_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input logic                 CLOCK_50,
  input logic                 RESET,
  genius_controller_if.master bus
);

  localparam int unsigned GapWidth = $clog2(GAP_CYCLES + 1);

  state_e              state_q;
  logic [GapWidth-1:0] gap_q;
  logic                enter_p;
  ctrl_t               ctrl;

  key_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_enter_sync (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (bus.KEY0_N),
    .pulse (enter_p)
  );

`ifndef GENIUS_TIMEOUT_EN
  logic unused_end_time;
  assign unused_end_time = bus.end_time;
`endif

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StInit;
      gap_q   <= '0;
    end else begin
      case (state_q)
        StInit:  state_q <= StSetup;
        StSetup: if (enter_p) state_q <= StSeq;
        StSeq: begin
          if (bus.end_FPGA) begin
            state_q <= StWait;
            gap_q   <= GapWidth'(GAP_CYCLES - 1);
          end
        end
        // Counter reaches zero in the last pause cycle, so WAIT spans GAP_CYCLES cycles.
        StWait: begin
          if (gap_q == '0) state_q <= StPlay;
          else             gap_q   <= gap_q - GapWidth'(1);
        end
        StPlay: begin
          if (bus.end_User) state_q <= StCheck;
`ifdef GENIUS_TIMEOUT_EN
          else if (bus.end_time) state_q <= StResult;
`endif
        end
        StCheck:  state_q <= (bus.match && !bus.win) ? StNext : StResult;
        StNext:   state_q <= StSeq;
        StResult: if (enter_p) state_q <= StInit;
        default:  state_q <= StInit;
      endcase
    end
  end

  assign ctrl    = decode_ctrl(state_q);
  assign bus.R1  = ctrl.r1;
  assign bus.R2  = ctrl.r2;
  assign bus.E1  = ctrl.e1;
  assign bus.E2  = ctrl.e2;
  assign bus.E3  = ctrl.e3;
  assign bus.E4  = ctrl.e4;
  assign bus.SEL = ctrl.sel;

endmodule

// File: tb/tb_genius_controller.sv
// Randomized scoreboard bench for genius_controller: a game-rule model predicts the control
// outputs for every cycle; a negedge monitor pops and compares them.
module tb_genius_controller;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned GAP    = 4;
  localparam int          NCYC   = 4000;
`ifdef GENIUS_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  genius_controller_if bus ();

  genius_controller #(
    .SYNC_STAGES (SYNC),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  typedef enum {M_INIT, M_SETUP, M_SEQ, M_WAIT, M_PLAY, M_CHECK, M_NEXT, M_RESULT} mstate_t;

  // {R1,R2,E1,E2,E3,E4,SEL} expected while the game is in a given phase.
  function automatic logic [6:0] expect_out(mstate_t s);
    case (s)
      M_INIT:   return 7'b1100000;
      M_SETUP:  return 7'b0010000;
      M_SEQ:    return 7'b0000100;
      M_PLAY:   return 7'b0001000;
      M_NEXT:   return 7'b0100010;
      M_RESULT: return 7'b0000001;
      default:  return 7'b0000000;
    endcase
  endfunction

  logic [6:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_on = 1'b0;
  int         mon_cyc = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      logic [6:0] got;
      logic [6:0] want;
      got = {bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: got %b, nothing expected", mon_cyc, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL outputs cycle %0d: got R1R2E1E2E3E4SEL=%b required %b",
                   mon_cyc, got, want);
        end
      end
      mon_cyc++;
    end
  end

  mstate_t st;
  mstate_t nx;
  int      wait_cnt;
  bit      hist[0:7];   // hist[i] = button held i+1 cycles ago
  bit      pressed;
  int      key_left;
  int      rst_left;
  bit      play_rst_done;
  bit      enter;
  bit      fp, eu, et, m, w;

  initial begin
    rst = 1'b1;
    bus.KEY0_N   = 1'b1;
    bus.end_FPGA = 1'b0;
    bus.end_User = 1'b0;
    bus.end_time = 1'b0;
    bus.win      = 1'b0;
    bus.match    = 1'b0;
    pressed = 1'b0;
    key_left = 5;
    rst_left = 2;
    play_rst_done = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;

    @(posedge clk);
    #1;
    st = M_INIT;
    exp_q.push_back(expect_out(M_INIT));
    mon_on = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0 || (st == M_PLAY && !play_rst_done)) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 2);
        if (st == M_PLAY) play_rst_done = 1'b1;
      end else begin
        rst = 1'b0;
      end

      if (key_left == 0) begin
        pressed  = ~pressed;
        key_left = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
      end else begin
        key_left--;
      end
      fp = ($urandom_range(0, 3) == 0);
      eu = ($urandom_range(0, 4) == 0);
      et = ($urandom_range(0, 4) == 0);
      m  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      bus.KEY0_N   = ~pressed;
      bus.end_FPGA = fp;
      bus.end_User = eu;
      bus.end_time = et;
      bus.match    = m;
      bus.win      = w;

      // A press is seen SYNC+1 cycles after the button goes down, once per press.
      enter = hist[SYNC] & ~hist[SYNC+1];

      if (rst) begin
        exp_q.delete();
        exp_q.push_back(expect_out(M_INIT));
        st = M_INIT;
        nx = M_INIT;
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
      end else begin
        nx = st;
        case (st)
          M_INIT:   nx = M_SETUP;
          M_SETUP:  if (enter) nx = M_SEQ;
          M_SEQ: begin
            if (fp) begin
              nx = M_WAIT;
              wait_cnt = 0;
            end
          end
          M_WAIT: begin
            wait_cnt++;
            if (wait_cnt == GAP) nx = M_PLAY;
          end
          M_PLAY: begin
            if (eu) nx = M_CHECK;
            else if (et && TimeoutEn) nx = M_RESULT;
          end
          M_CHECK:  nx = (m && !w) ? M_NEXT : M_RESULT;
          M_NEXT:   nx = M_SEQ;
          M_RESULT: if (enter) nx = M_INIT;
          default:  nx = M_INIT;
        endcase
      end

      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rst ? 1'b0 : pressed;

      exp_q.push_back(expect_out(nx));
      st = nx;
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
